btn_debounce_repeat: RTL and testbench

//  Front-end for a push button. Synchronizes the raw button input and removes chatter.

---
 rtl/btn_debounce_repeat.sv | 123 ++++++++++++
 tb/tb_btn_debounce_repeat.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce_repeat.sv
// Push-button front end: 2-FF synchronizer, tick-sampled debounce filter and
// a press/auto-repeat pulse generator with registered outputs.
module btn_debounce_repeat #(
    parameter int SAMPLE_DIV   = 125000,
    parameter int STABLE_CNT   = 4,
    parameter int HOLD_TICKS   = 500,
    parameter int REPEAT_TICKS = 100,
    parameter bit REPEAT_EN    = 1'b1
) (
    input  logic CLK,
    input  logic RST,
    input  logic BTNIN,
    output logic BTNOUT,
    output logic LEVEL
);

    localparam int TW   = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int SW   = $clog2(STABLE_CNT + 1);
    localparam int HMAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
    localparam int HW   = $clog2(HMAX + 1);

    localparam logic [TW-1:0] TICK_LAST   = TW'(SAMPLE_DIV - 1);
    localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CNT - 1);
    localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_TICKS - 1);
    localparam logic [HW-1:0] HOLD_SAT    = HW'(HOLD_TICKS);
    localparam logic [HW-1:0] REPEAT_LAST = HW'(REPEAT_TICKS - 1);

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

    logic          sync1;
    logic          s_in;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic [SW-1:0] stable_cnt;
    logic          level_nxt;
    logic [HW-1:0] hold_cnt;
    state_t        state;

    always_comb begin
        tick = (tick_cnt == TICK_LAST);
    end

    // Next LEVEL is looked ahead so the press pulse lands in the same cycle LEVEL rises.
    always_comb begin
        level_nxt = LEVEL;
        if (tick && (s_in != LEVEL) && (stable_cnt == STABLE_LAST)) begin
            level_nxt = s_in;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1      <= 1'b0;
            s_in       <= 1'b0;
            tick_cnt   <= '0;
            stable_cnt <= '0;
            LEVEL      <= 1'b0;
        end else begin
            sync1    <= BTNIN;
            s_in     <= sync1;
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            if (tick) begin
                if (s_in != LEVEL) begin
                    stable_cnt <= (stable_cnt == STABLE_LAST) ? '0 : stable_cnt + 1'b1;
                end else begin
                    stable_cnt <= '0;
                end
            end
            LEVEL <= level_nxt;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            hold_cnt <= '0;
            BTNOUT   <= 1'b0;
        end else begin
            BTNOUT <= 1'b0;
            if (LEVEL && !level_nxt) begin
                state    <= IDLE;
                hold_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (!LEVEL && level_nxt) begin
                            BTNOUT   <= 1'b1;
                            state    <= HOLD;
                            hold_cnt <= '0;
                        end
                    end
                    HOLD: begin
                        // Without repeat the counter parks at HOLD_TICKS and stays there.
                        if (tick && (hold_cnt != HOLD_SAT)) begin
                            if ((hold_cnt == HOLD_LAST) && REPEAT_EN) begin
                                BTNOUT   <= 1'b1;
                                state    <= REPEAT;
                                hold_cnt <= '0;
                            end else begin
                                hold_cnt <= hold_cnt + 1'b1;
                            end
                        end
                    end
                    REPEAT: begin
                        if (tick) begin
                            if (hold_cnt == REPEAT_LAST) begin
                                BTNOUT   <= 1'b1;
                                hold_cnt <= '0;
                            end else begin
                                hold_cnt <= hold_cnt + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        hold_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_btn_debounce_repeat.sv
// Directed bench: one repeating and one non-repeating instance share CLK/RST/BTNIN.
module tb_btn_debounce_repeat;

    logic CLK = 1'b0;
    logic RST;
    logic BTNIN;
    logic BTNOUT0, LEVEL0, BTNOUT1, LEVEL1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int r = 0;
    int np0 = 0, np1 = 0;
    int p0[$];
    int p1[$];
    logic prev0 = 1'b0, prev1 = 1'b0;

    btn_debounce_repeat #(
        .SAMPLE_DIV(4), .STABLE_CNT(3), .HOLD_TICKS(5), .REPEAT_TICKS(2), .REPEAT_EN(1'b1)
    ) dut0 (
        .CLK(CLK), .RST(RST), .BTNIN(BTNIN), .BTNOUT(BTNOUT0), .LEVEL(LEVEL0)
    );

    btn_debounce_repeat #(
        .SAMPLE_DIV(4), .STABLE_CNT(3), .HOLD_TICKS(5), .REPEAT_TICKS(2), .REPEAT_EN(1'b0)
    ) dut1 (
        .CLK(CLK), .RST(RST), .BTNIN(BTNIN), .BTNOUT(BTNOUT1), .LEVEL(LEVEL1)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Pulse recorder: cycle index of every BTNOUT pulse, plus a width check.
    always @(negedge CLK) begin
        if (BTNOUT0) begin
            np0++;
            p0.push_back(cyc);
            check_eq("width0", int'(prev0), 0);
        end
        if (BTNOUT1) begin
            np1++;
            p1.push_back(cyc);
            check_eq("width1", int'(prev1), 0);
        end
        prev0 = BTNOUT0;
        prev1 = BTNOUT1;
    end

    function automatic int pulse0(input int k);
        return (p0.size() > k) ? p0[k] : -1;
    endfunction

    function automatic int pulse1(input int k);
        return (p1.size() > k) ? p1[k] : -1;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic do_reset(input int n);
        RST = 1'b1;
        repeat (n) @(posedge CLK);
        #1;
        r = cyc;
        check_eq("rst_level0", int'(LEVEL0), 0);
        check_eq("rst_btnout0", int'(BTNOUT0), 0);
        check_eq("rst_level1", int'(LEVEL1), 0);
        RST = 1'b0;
        np0 = 0;
        np1 = 0;
        p0.delete();
        p1.delete();
    endtask

    initial begin
        int rise, t, d;
        bit seen, drop0, drop1;

        RST = 1'b1;
        BTNIN = 1'b0;

        // Tick period from reset: tick_cnt = 0 right after reset, tick when it reaches 3.
        do_reset(2);
        for (int k = 0; k < 9; k++) begin
            check_eq("tick", int'(dut0.tick), ((cyc - r) % 4 == 3) ? 1 : 0);
            step(1);
        end

        // Bounce every 3 cycles, then hold high.
        do_reset(2);
        step(2);
        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0) BTNIN = ~BTNIN;
            step(1);
        end
        BTNIN = 1'b1;
        t = cyc;
        rise = -1;
        for (int k = 0; k < 40; k++) begin
            step(1);
            if (LEVEL0) begin
                rise = cyc;
                break;
            end
        end
        d = (rise < 0) ? 1000 : rise - t;
        check_eq("bounce_rise_window", (d >= 11 && d <= 19) ? 1 : 0, 1);
        step(4);
        check_eq("bounce_pulses", np0, 1);
        check_eq("bounce_pulse_at_rise", pulse0(0), rise);
        BTNIN = 1'b0;
        step(30);

        // Clean hold, release timed so LEVEL falls on a repeat-due tick.
        do_reset(2);
        BTNIN = 1'b1;
        while (cyc < r + 69) step(1);
        BTNIN = 1'b0;
        while (cyc < r + 79) step(1);
        check_eq("hold_level_before_fall", int'(LEVEL0), 1);
        step(1);
        check_eq("hold_level_fall", int'(LEVEL0), 0);
        check_eq("hold_no_release_pulse", int'(BTNOUT0), 0);
        step(20);
        check_eq("hold_pulse_count", np0, 7);
        check_eq("hold_press_at", pulse0(0) - r, 12);
        check_eq("hold_rep1_at", pulse0(1) - r, 32);
        check_eq("hold_rep2_at", pulse0(2) - r, 40);
        check_eq("hold_rep3_at", pulse0(3) - r, 48);
        check_eq("hold_rep6_at", pulse0(6) - r, 72);
        check_eq("hold_norep_count", np1, 1);

        // Press glitch shorter than two ticks.
        do_reset(2);
        BTNIN = 1'b1;
        step(6);
        BTNIN = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            step(1);
            if (LEVEL0) seen = 1'b1;
        end
        check_eq("glitch_level", int'(seen), 0);
        check_eq("glitch_pulses", np0, 0);

        // Release glitch while held.
        BTNIN = 1'b1;
        step(24);
        check_eq("relglitch_level_up", int'(LEVEL1), 1);
        check_eq("relglitch_press", np1, 1);
        BTNIN = 1'b0;
        step(6);
        BTNIN = 1'b1;
        drop0 = 1'b0;
        drop1 = 1'b0;
        for (int k = 0; k < 40; k++) begin
            step(1);
            if (!LEVEL0) drop0 = 1'b1;
            if (!LEVEL1) drop1 = 1'b1;
        end
        check_eq("relglitch_drop0", int'(drop0), 0);
        check_eq("relglitch_drop1", int'(drop1), 0);
        check_eq("relglitch_pulses1", np1, 1);
        BTNIN = 1'b0;
        step(30);

        // One-cycle reset in REPEAT with the button held.
        do_reset(2);
        BTNIN = 1'b1;
        while (cyc < r + 44) step(1);
        check_eq("rptrst_pre_pulses", np0, 3);
        do_reset(1);
        while (cyc < r + 34) step(1);
        check_eq("rptrst_press_at", pulse0(0) - r, 12);
        check_eq("rptrst_rep1_at", pulse0(1) - r, 32);
        check_eq("rptrst_count", np0, 2);
        BTNIN = 1'b0;
        step(30);

        // Long hold: repeat instance keeps stepping, non-repeat instance pulses once.
        do_reset(2);
        BTNIN = 1'b1;
        step(400);
        check_eq("long_rep_count0", np0, 47);
        check_eq("long_count1", np1, 1);
        check_eq("long_press1_at", pulse1(0) - r, 12);
        BTNIN = 1'b0;
        step(30);
        check_eq("long_release_level1", int'(LEVEL1), 0);
        BTNIN = 1'b1;
        step(40);
        check_eq("long_repress_count1", np1, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
